// File: rtl/pa_fdsu_pkg.sv
// rtl/pa_fdsu_pkg.sv - shared FSM states, rounding modes and width helpers for the FDSU prep stage
package pa_fdsu_pkg;

  localparam int EXPNT_W = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM0 = 2'd1,
    ST_NORM1 = 2'd2,
    ST_DONE  = 2'd3
  } fdsu_state_e;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  function automatic int fdsu_expw(input int flen);
    return (flen == 64) ? 11 : 8;
  endfunction

  function automatic int fdsu_fracw(input int flen);
    return (flen == 64) ? 52 : 23;
  endfunction

  function automatic int fdsu_bias(input int flen);
    return (flen == 64) ? 1023 : 127;
  endfunction

  // Overflow-to-largest-finite flag: set when the rounding direction points toward zero for this sign.
  function automatic logic fdsu_lfn(input logic [2:0] rm, input logic sign);
    case (rm)
      RM_RTZ:  return 1'b1;
      RM_RDN:  return !sign;
      RM_RUP:  return sign;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pa_fdsu_lzc.sv
// rtl/pa_fdsu_lzc.sv - combinational leading-zero count; an all-zero input returns W
module pa_fdsu_lzc #(
  parameter int W  = 23,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data_i,
  output logic [CW-1:0] cnt_o
);

  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (data_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/pa_fdsu_prep_seq.sv
// rtl/pa_fdsu_prep_seq.sv - operand capture and denormal pre-normalisation ahead of the FDSU divide/sqrt core
module pa_fdsu_prep_seq
  import pa_fdsu_pkg::*;
#(
  parameter int FLEN = 32,
  localparam int EXPW  = fdsu_expw(FLEN),
  localparam int FRACW = fdsu_fracw(FLEN),
  localparam int MW    = FRACW + 1,
  localparam int BIAS  = fdsu_bias(FLEN),
  localparam int REMW  = MW + 8
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst,
  input  logic                 fdsu_flush,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [1:0]           in_func,
  input  logic [FLEN-1:0]      in_srcf0,
  input  logic [FLEN-1:0]      in_srcf1,
  input  logic [2:0]           in_rm,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic                 out_div,
  output logic                 out_sqrt,
  output logic                 out_result_sign,
  output logic                 out_of_result_lfn,
  output logic                 out_op1_id_vld,
  output logic [2:0]           out_rm,
  output logic [EXPNT_W-1:0]   out_expnt_adder_op0,
  output logic [EXPNT_W-1:0]   out_expnt_adder_op1,
  output logic [REMW-1:0]      out_remainder,
  output logic [MW-1:0]        out_divisor
);

  localparam int LZW = $clog2(FRACW + 1);

  fdsu_state_e state_q, state_d;
  logic accept;
  logic load_out;

  logic [EXPW-1:0]    exp_fld0, exp_fld1;
  logic               in_id0, in_id1;

  logic [1:0]         func_q, func_d;
  logic [2:0]         rm_q, rm_d;
  logic               sign0_q, sign0_d, sign1_q, sign1_d;
  logic               id1_q, id1_d;
  logic [FRACW-1:0]   frac0_q, frac0_d, frac1_q, frac1_d;
  logic [MW-1:0]      mant0_q, mant0_d, mant1_q, mant1_d;
  logic [EXPNT_W-1:0] exp0_q, exp0_d, exp1_q, exp1_d;

  logic [FRACW-1:0]   lzc_in;
  logic [LZW-1:0]     lz_cnt;
  logic [MW-1:0]      norm_mant;
  logic [EXPNT_W-1:0] norm_exp;

  logic               res_sign;
  logic [EXPNT_W-1:0] op1_nxt;
  logic [MW-1:0]      divisor_nxt;
  logic [REMW-1:0]    rem_nxt;

  logic               out_div_q, out_sqrt_q, out_sign_q, out_lfn_q, out_id1_q;
  logic [2:0]         out_rm_q;
  logic [EXPNT_W-1:0] out_op0_q, out_op1_q;
  logic [REMW-1:0]    out_rem_q;
  logic [MW-1:0]      out_dvs_q;

  assign exp_fld0 = in_srcf0[FLEN-2 -: EXPW];
  assign exp_fld1 = in_srcf1[FLEN-2 -: EXPW];
  assign in_id0   = (exp_fld0 == '0);
  assign in_id1   = in_func[1] && (exp_fld1 == '0);

  // Flush wins over a same-cycle request, so readiness is withdrawn while it is high.
  assign in_rdy = !fdsu_flush &&
                  ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_rdy));
  assign accept = in_vld && in_rdy;

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORM0: state_d = id1_q ? ST_NORM1 : ST_DONE;
      ST_NORM1: state_d = ST_DONE;
      ST_DONE:  if (out_rdy) state_d = ST_IDLE;
      default:  state_d = state_q;
    endcase
    if (accept)     state_d = in_id0 ? ST_NORM0 : (in_id1 ? ST_NORM1 : ST_DONE);
    if (fdsu_flush) state_d = ST_IDLE;
  end

  // One counter serves both operands: NORM0 works on op0, NORM1 on op1.
  assign lzc_in = (state_q == ST_NORM1) ? frac1_q : frac0_q;

  pa_fdsu_lzc #(
    .W  (FRACW),
    .CW (LZW)
  ) u_lzc (
    .data_i (lzc_in),
    .cnt_o  (lz_cnt)
  );

  assign norm_mant = {lzc_in, 1'b0} << lz_cnt;
  assign norm_exp  = EXPNT_W'(0) - EXPNT_W'(lz_cnt);

  always_comb begin
    func_d  = func_q;
    rm_d    = rm_q;
    sign0_d = sign0_q;
    sign1_d = sign1_q;
    id1_d   = id1_q;
    frac0_d = frac0_q;
    frac1_d = frac1_q;
    mant0_d = mant0_q;
    exp0_d  = exp0_q;
    mant1_d = mant1_q;
    exp1_d  = exp1_q;
    if (accept) begin
      func_d  = in_func;
      rm_d    = in_rm;
      sign0_d = in_srcf0[FLEN-1];
      sign1_d = in_srcf1[FLEN-1];
      id1_d   = in_id1;
      frac0_d = in_srcf0[FRACW-1:0];
      frac1_d = in_srcf1[FRACW-1:0];
      // Normal-operand values; a denormal operand is rewritten in its NORM state.
      mant0_d = {1'b1, in_srcf0[FRACW-1:0]};
      exp0_d  = {{(EXPNT_W-EXPW){1'b0}}, exp_fld0};
      mant1_d = {1'b1, in_srcf1[FRACW-1:0]};
      exp1_d  = {{(EXPNT_W-EXPW){1'b0}}, exp_fld1};
    end else if (state_q == ST_NORM0) begin
      mant0_d = norm_mant;
      exp0_d  = norm_exp;
    end else if (state_q == ST_NORM1) begin
      mant1_d = norm_mant;
      exp1_d  = norm_exp;
    end
  end

  always_comb begin
    res_sign    = func_d[1] ? (sign0_d ^ sign1_d) : sign0_d;
    op1_nxt     = '0;
    divisor_nxt = '0;
    rem_nxt     = '0;
    if (func_d[1]) begin
      op1_nxt     = exp1_d;
      divisor_nxt = mant1_d;
      rem_nxt     = {5'b0, mant0_d, 3'b0};
    end else if (func_d[0]) begin
      op1_nxt = EXPNT_W'(BIAS);
      rem_nxt = exp0_d[0] ? {6'b0, mant0_d, 2'b0} : {5'b0, mant0_d, 3'b0};
    end
  end

  // Results load only on entry to DONE, so they hold while the consumer stalls.
  assign load_out = (state_d == ST_DONE) && ((state_q != ST_DONE) || accept);

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      func_q     <= '0;
      rm_q       <= '0;
      sign0_q    <= 1'b0;
      sign1_q    <= 1'b0;
      id1_q      <= 1'b0;
      frac0_q    <= '0;
      frac1_q    <= '0;
      mant0_q    <= '0;
      exp0_q     <= '0;
      mant1_q    <= '0;
      exp1_q     <= '0;
      out_div_q  <= 1'b0;
      out_sqrt_q <= 1'b0;
      out_sign_q <= 1'b0;
      out_lfn_q  <= 1'b0;
      out_id1_q  <= 1'b0;
      out_rm_q   <= '0;
      out_op0_q  <= '0;
      out_op1_q  <= '0;
      out_rem_q  <= '0;
      out_dvs_q  <= '0;
    end else begin
      func_q  <= func_d;
      rm_q    <= rm_d;
      sign0_q <= sign0_d;
      sign1_q <= sign1_d;
      id1_q   <= id1_d;
      frac0_q <= frac0_d;
      frac1_q <= frac1_d;
      mant0_q <= mant0_d;
      exp0_q  <= exp0_d;
      mant1_q <= mant1_d;
      exp1_q  <= exp1_d;
      if (load_out) begin
        out_div_q  <= func_d[1];
        out_sqrt_q <= func_d[0];
        out_sign_q <= res_sign;
        out_lfn_q  <= fdsu_lfn(rm_d, res_sign);
        out_id1_q  <= id1_d;
        out_rm_q   <= rm_d;
        out_op0_q  <= exp0_d;
        out_op1_q  <= op1_nxt;
        out_rem_q  <= rem_nxt;
        out_dvs_q  <= divisor_nxt;
      end
    end
  end

  assign out_vld             = (state_q == ST_DONE);
  assign out_div             = out_div_q;
  assign out_sqrt            = out_sqrt_q;
  assign out_result_sign     = out_sign_q;
  assign out_of_result_lfn   = out_lfn_q;
  assign out_op1_id_vld      = out_id1_q;
  assign out_rm              = out_rm_q;
  assign out_expnt_adder_op0 = out_op0_q;
  assign out_expnt_adder_op1 = out_op1_q;
  assign out_remainder       = out_rem_q;
  assign out_divisor         = out_dvs_q;

endmodule

// File: tb/tb_pa_fdsu_prep_seq.sv
// tb/tb_pa_fdsu_prep_seq.sv - directed bench with a queue-based reference model for pa_fdsu_prep_seq
module tb_pa_fdsu_prep_seq;

  localparam logic [1:0] F_DIV  = 2'b10;
  localparam logic [1:0] F_SQRT = 2'b01;

  logic        clk;
  logic        cpurst, fdsu_flush, in_vld, in_rdy, out_vld, out_rdy;
  logic [1:0]  in_func;
  logic [31:0] in_srcf0, in_srcf1;
  logic [2:0]  in_rm;
  logic        out_div, out_sqrt, out_result_sign, out_of_result_lfn, out_op1_id_vld;
  logic [2:0]  out_rm;
  logic [12:0] out_expnt_adder_op0, out_expnt_adder_op1;
  logic [31:0] out_remainder;
  logic [23:0] out_divisor;

  pa_fdsu_prep_seq #(.FLEN(32)) dut (
    .forever_cpuclk      (clk),
    .cpurst              (cpurst),
    .fdsu_flush          (fdsu_flush),
    .in_vld              (in_vld),
    .in_rdy              (in_rdy),
    .in_func             (in_func),
    .in_srcf0            (in_srcf0),
    .in_srcf1            (in_srcf1),
    .in_rm               (in_rm),
    .out_vld             (out_vld),
    .out_rdy             (out_rdy),
    .out_div             (out_div),
    .out_sqrt            (out_sqrt),
    .out_result_sign     (out_result_sign),
    .out_of_result_lfn   (out_of_result_lfn),
    .out_op1_id_vld      (out_op1_id_vld),
    .out_rm              (out_rm),
    .out_expnt_adder_op0 (out_expnt_adder_op0),
    .out_expnt_adder_op1 (out_expnt_adder_op1),
    .out_remainder       (out_remainder),
    .out_divisor         (out_divisor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] op0, op1;
    logic [31:0] rem;
    logic [23:0] dvs;
    logic        sign, lfn, id1, dv, sq;
    logic [2:0]  rm;
    int          lat;
    int          due;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   pop_last = 0;
  int   pop_prev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Real mantissa/exponent of a single-precision operand, denormals scaled until the hidden bit is set.
  function automatic void norm(input logic [31:0] f, output int m, output int e);
    int frac, ef, lz;
    frac = int'(f[22:0]);
    ef   = int'(f[30:23]);
    if (ef != 0) begin
      m = frac + (1 << 23);
      e = ef;
    end else begin
      m  = frac * 2;
      lz = 0;
      if (frac == 0) lz = 23;
      else while (m < (1 << 23)) begin
        m = m * 2;
        lz++;
      end
      e = (8192 - lz) % 8192;
    end
  endfunction

  function automatic exp_t model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] rm);
    exp_t r;
    int   m0, x0, m1, x1;
    bit   dv, sq;
    dv = (f == F_DIV);
    sq = (f == F_SQRT);
    norm(a, m0, x0);
    norm(b, m1, x1);
    r.dv  = dv;
    r.sq  = sq;
    r.rm  = rm;
    r.op0 = 13'(x0);
    r.op1 = dv ? 13'(x1) : (sq ? 13'd127 : 13'd0);
    r.dvs = dv ? 24'(m1) : 24'd0;
    if (dv || (sq && (x0 % 2 == 0))) r.rem = 32'(m0 * 8);
    else if (sq)                     r.rem = 32'(m0 * 4);
    else                             r.rem = 32'd0;
    r.sign = a[31] ^ (dv & b[31]);
    case (rm)
      3'd1:    r.lfn = 1'b1;
      3'd2:    r.lfn = !r.sign;
      3'd3:    r.lfn = r.sign;
      default: r.lfn = 1'b0;
    endcase
    r.id1 = dv && (b[30:23] == 8'd0);
    r.lat = 1 + ((a[30:23] == 8'd0) ? 1 : 0) + (r.id1 ? 1 : 0);
    r.due = 0;
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    bit   ev, er;
    if (cpurst) begin
      q.delete();
    end else begin
      ev = (q.size() > 0) && (cyc >= q[0].due);
      er = !fdsu_flush && ((q.size() == 0) || (ev && out_rdy));
      chk("out_vld", 64'(out_vld), 64'(ev));
      chk("in_rdy", 64'(in_rdy), 64'(er));
      if (ev && out_vld) begin
        chk("op0", 64'(out_expnt_adder_op0), 64'(q[0].op0));
        chk("op1", 64'(out_expnt_adder_op1), 64'(q[0].op1));
        chk("remainder", 64'(out_remainder), 64'(q[0].rem));
        chk("divisor", 64'(out_divisor), 64'(q[0].dvs));
        chk("sign", 64'(out_result_sign), 64'(q[0].sign));
        chk("lfn", 64'(out_of_result_lfn), 64'(q[0].lfn));
        chk("id1", 64'(out_op1_id_vld), 64'(q[0].id1));
        chk("rm", 64'(out_rm), 64'(q[0].rm));
        chk("div", 64'(out_div), 64'(q[0].dv));
        chk("sqrt", 64'(out_sqrt), 64'(q[0].sq));
      end
      if (fdsu_flush) begin
        q.delete();
      end else begin
        if (ev && out_rdy) begin
          void'(q.pop_front());
          pop_prev = pop_last;
          pop_last = cyc;
        end
        if (in_vld && er) begin
          e     = model(in_func, in_srcf0, in_srcf1, in_rm);
          e.due = cyc + e.lat;
          q.push_back(e);
        end
      end
    end
  end

  task automatic send(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] rm);
    bit done;
    done     = 1'b0;
    in_vld   = 1'b1;
    in_func  = f;
    in_srcf0 = a;
    in_srcf1 = b;
    in_rm    = rm;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_rdy) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_vld = 1'b0;
    chk("send_accept", 64'(done), 64'(1));
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (q.size() != 0 && i < 40) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("drain", 64'(q.size()), 64'(0));
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    chk({tag, "_vld"}, 64'(out_vld), 64'(0));
    chk({tag, "_rdy"}, 64'(in_rdy), 64'(1));
    chk({tag, "_flags"}, 64'({out_div, out_sqrt, out_result_sign, out_of_result_lfn, out_op1_id_vld}), 64'(0));
    chk({tag, "_rm"}, 64'(out_rm), 64'(0));
    chk({tag, "_op0"}, 64'(out_expnt_adder_op0), 64'(0));
    chk({tag, "_op1"}, 64'(out_expnt_adder_op1), 64'(0));
    chk({tag, "_rem"}, 64'(out_remainder), 64'(0));
    chk({tag, "_dvs"}, 64'(out_divisor), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t m;
    cpurst = 1'b1;  fdsu_flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
    in_func = 2'b00; in_srcf0 = '0;  in_srcf1 = '0;  in_rm = 3'b000;

    m = model(F_DIV, 32'h40C00000, 32'h40000000, 3'b000);
    chk("pin43_op0", 64'(m.op0), 64'h081);
    chk("pin43_op1", 64'(m.op1), 64'h080);
    chk("pin43_dvs", 64'(m.dvs), 64'h800000);
    chk("pin43_rem", 64'(m.rem), 64'h06000000);
    chk("pin43_lat", 64'(m.lat), 64'd1);
    m = model(F_SQRT, 32'h40800000, 32'h0, 3'b000);
    chk("pin44_op1", 64'(m.op1), 64'h07F);
    chk("pin44_rem", 64'(m.rem), 64'h02000000);
    m = model(F_DIV, 32'h00000001, 32'hC0400000, 3'b010);
    chk("pin45_op0", 64'(m.op0), 64'h1FEA);
    chk("pin45_rem", 64'(m.rem), 64'h04000000);
    chk("pin45_sl", 64'({m.sign, m.lfn, m.id1}), 64'b100);
    chk("pin45_lat", 64'(m.lat), 64'd2);
    m = model(F_DIV, 32'h00400000, 32'h00000003, 3'b000);
    chk("pin46_op0", 64'(m.op0), 64'h0000);
    chk("pin46_op1", 64'(m.op1), 64'h1FEB);
    chk("pin46_id1", 64'(m.id1), 64'd1);
    chk("pin46_lat", 64'(m.lat), 64'd3);

    repeat (2) @(posedge clk);
    #1;
    cpurst = 1'b0;
    check_zero("reset");

    send(F_DIV,  32'h40C00000, 32'h40000000, 3'b000); drain();
    send(F_SQRT, 32'h40800000, 32'h00000000, 3'b001); drain();
    send(F_SQRT, 32'h40000000, 32'h00000005, 3'b100); drain();
    send(F_DIV,  32'h00000001, 32'hC0400000, 3'b010); drain();
    send(F_DIV,  32'h00000001, 32'hC0400000, 3'b011); drain();
    send(F_DIV,  32'h00400000, 32'h00000003, 3'b101); drain();
    send(F_SQRT, 32'h00000001, 32'h00000001, 3'b110); drain();
    send(F_SQRT, 32'h00000003, 32'h00000000, 3'b011); drain();
    send(2'b00,  32'h3F800000, 32'h00000000, 3'b111); drain();
    send(F_DIV,  32'h80000000, 32'h00000000, 3'b001); drain();
    send(F_DIV,  32'hBF800000, 32'h3F800000, 3'b010); drain();

    // Back-pressure: result held for five stalled cycles while a new request waits.
    out_rdy = 1'b0;
    send(F_DIV, 32'h40C00000, 32'hC0000000, 3'b011);
    in_vld = 1'b1; in_func = F_SQRT; in_srcf0 = 32'h40800000; in_srcf1 = 32'h0; in_rm = 3'b000;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("bp_vld", 64'(out_vld), 64'(1));
    chk("bp_rdy", 64'(in_rdy), 64'(0));
    chk("bp_rem", 64'(out_remainder), 64'h06000000);
    chk("bp_sl", 64'({out_result_sign, out_of_result_lfn}), 64'b11);
    @(posedge clk);
    #1;
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    drain();

    // Flush in NORM0 discards the operation.
    send(F_DIV, 32'h00400000, 32'h40000000, 3'b000);
    fdsu_flush = 1'b1;
    @(posedge clk);
    #1;
    fdsu_flush = 1'b0;
    @(negedge clk);
    chk("flush_rdy", 64'(in_rdy), 64'(1));
    chk("flush_vld", 64'(out_vld), 64'(0));
    repeat (4) begin
      @(posedge clk);
      #1;
    end

    // Flush in DONE with a competing request: the request is refused.
    send(F_DIV, 32'h40C00000, 32'h40000000, 3'b000);
    fdsu_flush = 1'b1;
    in_vld = 1'b1; in_func = F_DIV; in_srcf0 = 32'h3F800000; in_srcf1 = 32'h3F800000;
    @(posedge clk);
    #1;
    fdsu_flush = 1'b0;
    in_vld = 1'b0;
    @(negedge clk);
    chk("flush2_vld", 64'(out_vld), 64'(0));
    @(posedge clk);
    #1;

    // Reset while in NORM1 clears every output.
    send(F_DIV, 32'h00000001, 32'h00000002, 3'b011);
    @(posedge clk);
    #1;
    cpurst = 1'b1;
    @(posedge clk);
    #1;
    cpurst = 1'b0;
    check_zero("rst_mid");

    // Back-to-back normal requests.
    send(F_DIV,  32'h40C00000, 32'h40000000, 3'b000);
    send(F_SQRT, 32'h40800000, 32'h00000000, 3'b001);
    drain();
    chk("b2b_gap", 64'(pop_last - pop_prev), 64'(1));

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
